// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem and
// presents words through a one-entry valid/ready stage. Define IFETCH_STATS_EN for fetch/stall counters.
module ifetch_ctrl #(
  parameter int          ADDR_W      = 4,
  parameter int          INSTR_W     = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               busy,
`ifdef IFETCH_STATS_EN
  output logic [7:0]         fetch_cnt,
  output logic [7:0]         stall_cnt,
`endif
  output logic               halted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;

  logic fire;
  logic load;
  logic is_halt_word;
  logic start_ok;
  logic pc_at_end;

  assign fire         = valid_q & if_ready;
  assign load         = ~valid_q | fire;
  assign is_halt_word = (imem_instr[INSTR_W-1:INSTR_W-4] == HALT_OPCODE);
  assign start_ok     = start & ((state_q == ST_IDLE) | (state_q == ST_HALT));
  assign pc_at_end    = (pc_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
        end else if (load) begin
          // The HALT word itself is swallowed; only a pending word may still drain.
          if (is_halt_word) begin
            valid_d = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            valid_d = 1'b1;
            instr_d = imem_instr;
            ifpc_d  = pc_q;
            if (pc_at_end) begin
              state_d = ST_DRAIN;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else begin
          if (fire) begin
            valid_d = 1'b0;
          end
          if (!valid_q || fire) begin
            state_d = ST_HALT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign busy      = (state_q == ST_FETCH) | (state_q == ST_DRAIN);
  assign halted    = (state_q == ST_HALT);

`ifdef IFETCH_STATS_EN
  logic [7:0] fetch_cnt_q, fetch_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      fetch_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (fire && (fetch_cnt_q != 8'hFF)) begin
        fetch_cnt_d = fetch_cnt_q + 8'd1;
      end
      if (valid_q && !if_ready && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed runs against a word-stream model
// (expected next PC, HALT/end stop, redirect) plus literal spot checks.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic [3:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [3:0]  if_pc;
  logic        busy;
  logic        halted;
`ifdef IFETCH_STATS_EN
  logic [7:0]  fetch_cnt;
  logic [7:0]  stall_cnt;
`endif

  logic [15:0] mem  [16];
  logic [15:0] demo [16];
  assign imem_instr = mem[imem_addr];

  ifetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .busy           (busy),
`ifdef IFETCH_STATS_EN
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt),
`endif
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  logic [15:0] got_instr [$];
  logic [3:0]  got_pc    [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream model: which address must be presented next, and whether a run is live.
  logic [3:0]  exp_pc;
  bit          m_run;
  bit          prev_stall;
  logic [15:0] prev_instr;
  logic [3:0]  prev_pc;

  initial begin
    exp_pc     = '0;
    m_run      = 0;
    prev_stall = 0;
    prev_instr = '0;
    prev_pc    = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy_halted_excl", {31'd0, busy & halted}, 32'd0);
        if (if_valid) begin
          check("if_pc_seq", {28'd0, if_pc}, {28'd0, exp_pc});
          check("if_instr_mem", {16'd0, if_instr}, {16'd0, mem[exp_pc]});
        end
        if (prev_stall) begin
          check("stall_valid", {31'd0, if_valid}, 32'd1);
          check("stall_instr", {16'd0, if_instr}, {16'd0, prev_instr});
          check("stall_pc", {28'd0, if_pc}, {28'd0, prev_pc});
        end
        prev_stall = if_valid && !if_ready && !rst && !redirect_valid;
        prev_instr = if_instr;
        prev_pc    = if_pc;
        if (rst) begin
          m_run  = 0;
          exp_pc = '0;
        end else begin
          if (if_valid && if_ready) begin
            got_instr.push_back(if_instr);
            got_pc.push_back(if_pc);
            $display("fire pc=%0d instr=0x%04h", if_pc, if_instr);
            if (exp_pc == 4'd15) begin
              m_run = 0;
            end else begin
              exp_pc = exp_pc + 4'd1;
              if (mem[exp_pc][15:12] == 4'hF) m_run = 0;
            end
          end
          if (m_run && redirect_valid) begin
            exp_pc = redirect_pc;
            m_run  = (mem[redirect_pc][15:12] != 4'hF);
          end else if (!m_run && start) begin
            exp_pc = '0;
            m_run  = (mem[0][15:12] != 4'hF);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_halt(input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      step();
      n++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic pulse_start();
    got_instr.delete();
    got_pc.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_demo_stream(input string name);
    check({name, "_count"}, got_instr.size(), 32'd16);
    for (int i = 0; i < 16 && i < got_instr.size(); i++) begin
      check({name, "_instr"}, {16'd0, got_instr[i]}, {16'd0, demo[i]});
      check({name, "_pc"}, {28'd0, got_pc[i]}, i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt2;
    demo = '{16'h1205, 16'h1402, 16'h2680, 16'h0858, 16'h0B08, 16'h3541,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 16; i++) mem[i] = demo[i];
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    step();
    step();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_addr", {28'd0, imem_addr}, 32'd0);
    check("rst_instr", {16'd0, if_instr}, 32'd0);
    check("rst_ifpc", {28'd0, if_pc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    chk_en = 1;

    // Demo program at full throughput; a stray start mid-run must be ignored.
    pulse_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_valid0", {31'd0, if_valid}, 32'd0);
    check("t1_addr0", {28'd0, imem_addr}, 32'd0);
    step();
    check("t1_first_valid", {31'd0, if_valid}, 32'd1);
    check("t1_first_instr", {16'd0, if_instr}, 32'h1205);
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_halt(40);
    check_demo_stream("t1");
    check("t1_busy_end", {31'd0, busy}, 32'd0);
`ifdef IFETCH_STATS_EN
    check("t1_fetch_cnt", {24'd0, fetch_cnt}, 32'd16);
    check("t1_stall_cnt", {24'd0, stall_cnt}, 32'd0);
`endif
    redirect_valid = 1'b1; redirect_pc = 4'd7;
    step();
    redirect_valid = 1'b0;
    check("halt_redirect_halted", {31'd0, halted}, 32'd1);
    check("halt_redirect_addr", {28'd0, imem_addr}, 32'd15);
    check("halt_redirect_valid", {31'd0, if_valid}, 32'd0);

    // Backpressure on PC 2 for three cycles.
    pulse_start();
    step();
    step();
    step();
    check("t2_pc2", {28'd0, if_pc}, 32'd2);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_instr", {16'd0, if_instr}, 32'h2680);
      check("t2_hold_addr", {28'd0, imem_addr}, 32'd3);
    end
`ifdef IFETCH_STATS_EN
    check("t2_stall_cnt", {24'd0, stall_cnt}, 32'd3);
`endif
    if_ready = 1'b1;
    run_to_halt(40);
    check_demo_stream("t2");

    // HALT opcode at address 4.
    mem[4] = 16'hF000;
    pulse_start();
    run_to_halt(40);
    check("t3_count", got_instr.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      check("t3_pc", {28'd0, got_pc[i]}, i);
    end
`ifdef IFETCH_STATS_EN
    check("t3_fetch_cnt", {24'd0, fetch_cnt}, 32'd4);
`endif
    mem[4] = 16'h0B08;

    // Redirect to 5 while PC 1 is being accepted.
    pulse_start();
    step();
    step();
    check("t4_pc1", {28'd0, if_pc}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 4'd5;
    step();
    redirect_valid = 1'b0;
    check("t4_flush_valid", {31'd0, if_valid}, 32'd0);
    check("t4_flush_addr", {28'd0, imem_addr}, 32'd5);
    step();
    check("t4_target_valid", {31'd0, if_valid}, 32'd1);
    check("t4_target_pc", {28'd0, if_pc}, 32'd5);
    check("t4_target_instr", {16'd0, if_instr}, 32'h3541);
    run_to_halt(40);
    check("t4_count", got_instr.size(), 32'd13);
    cnt2 = 0;
    foreach (got_pc[i]) if (got_pc[i] == 4'd2) cnt2++;
    check("t4_no_pc2", cnt2, 32'd0);

    // Reset in the middle of a run.
    pulse_start();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", {31'd0, if_valid}, 32'd0);
    check("t5_addr", {28'd0, imem_addr}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_halted", {31'd0, halted}, 32'd0);
    pulse_start();
    run_to_halt(40);
    check_demo_stream("t5");

    // Restart from HALT.
    pulse_start();
    check("t6_halted", {31'd0, halted}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_addr", {28'd0, imem_addr}, 32'd0);
`ifdef IFETCH_STATS_EN
    check("t6_fetch_cnt", {24'd0, fetch_cnt}, 32'd0);
    check("t6_stall_cnt", {24'd0, stall_cnt}, 32'd0);
`endif
    step();
    check("t6_valid", {31'd0, if_valid}, 32'd1);
    check("t6_pc0", {28'd0, if_pc}, 32'd0);
    run_to_halt(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
